// File: rtl/frv_rvfi_tracer.sv
// RVFI trace producer: one registered record per retirement.
// Wide writeback fields are built only with FRV_RVFI_WIDE_EN.
module frv_rvfi_tracer #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            trs_valid,
  input  logic [XLEN-1:0] trs_pc,
  input  logic [XLEN-1:0] trs_pc_next,
  input  logic [ILEN-1:0] trs_insn,
  input  logic            trs_trap,
  input  logic            trs_halt,
  input  logic [4:0]      trs_rs1_addr,
  input  logic [4:0]      trs_rs2_addr,
  input  logic [4:0]      trs_rs3_addr,
  input  logic [XLEN-1:0] trs_rs1_rdata,
  input  logic [XLEN-1:0] trs_rs2_rdata,
  input  logic [XLEN-1:0] trs_rs3_rdata,
  input  logic [4:0]      trs_rd_addr,
  input  logic [XLEN-1:0] trs_rd_wdata,
  input  logic [XLEN-1:0] trs_rd_wdatahi,
  input  logic            trs_rd_wide,
  input  logic            trs_mem,
  input  logic            dmem_req,
  input  logic            dmem_gnt,
  input  logic            dmem_wen,
  input  logic [3:0]      dmem_strb,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_recv,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rvfi_valid,
  output logic            rvfi_trap,
  output logic            rvfi_halt,
  output logic            rvfi_intr,
  output logic [63:0]     rvfi_order,
  output logic [ILEN-1:0] rvfi_insn,
  output logic [4:0]      rvfi_rs1_addr,
  output logic [4:0]      rvfi_rs2_addr,
  output logic [4:0]      rvfi_rs3_addr,
  output logic [XLEN-1:0] rvfi_rs1_rdata,
  output logic [XLEN-1:0] rvfi_rs2_rdata,
  output logic [XLEN-1:0] rvfi_rs3_rdata,
  output logic [4:0]      rvfi_rd_addr,
  output logic [XLEN-1:0] rvfi_rd_wdata,
  output logic [XLEN-1:0] rvfi_rd_wdatahi,
  output logic            rvfi_rd_wide,
  output logic [XLEN-1:0] rvfi_pc_rdata,
  output logic [XLEN-1:0] rvfi_pc_wdata,
  output logic [XLEN-1:0] rvfi_mem_addr,
  output logic [XLEN-1:0] rvfi_mem_rdata,
  output logic [XLEN-1:0] rvfi_mem_wdata,
  output logic [3:0]      rvfi_mem_rmask,
  output logic [3:0]      rvfi_mem_wmask
);

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_REQ,
    MC_DONE
  } mc_state_e;

  typedef struct packed {
    logic            trap;
    logic            halt;
    logic            intr;
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic [4:0]      rs1_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rs3_addr;
    logic [XLEN-1:0] rs3_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] rd_wdatahi;
    logic            rd_wide;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
  } rec_t;

  mc_state_e       mc_state_q, mc_state_d;
  logic [XLEN-1:0] mc_addr_q, mc_addr_d;
  logic [3:0]      mc_strb_q, mc_strb_d;
  logic            mc_wen_q, mc_wen_d;
  logic [XLEN-1:0] mc_wdata_q, mc_wdata_d;
  logic [XLEN-1:0] mc_rdata_q, mc_rdata_d;

  rec_t            rec_q, rec_d;
  logic            valid_q;
  logic [63:0]     order_q;
  logic            intr_q;
  logic            halted_q;

  logic            accept;
  logic            consume;
  logic            grant;
  logic            mem_ok;
  logic [XLEN-1:0] ld_rdata;

  assign accept  = trs_valid && !halted_q;
  assign consume = accept && trs_mem;
  assign grant   = dmem_req && dmem_gnt;

  // Memory capture next state; a consuming retirement wins over progress.
  always_comb begin
    mc_state_d = mc_state_q;
    mc_addr_d  = mc_addr_q;
    mc_strb_d  = mc_strb_q;
    mc_wen_d   = mc_wen_q;
    mc_wdata_d = mc_wdata_q;
    mc_rdata_d = mc_rdata_q;
    unique case (mc_state_q)
      MC_IDLE: begin
        if (grant) begin
          mc_state_d = MC_REQ;
          mc_addr_d  = dmem_addr & ~XLEN'(3);
          mc_strb_d  = dmem_strb;
          mc_wen_d   = dmem_wen;
          mc_wdata_d = dmem_wen ? dmem_wdata : '0;
          mc_rdata_d = '0;
        end
      end
      MC_REQ: begin
        if (dmem_recv) begin
          mc_state_d = MC_DONE;
          if (!mc_wen_q) mc_rdata_d = dmem_rdata;
        end
      end
      MC_DONE: begin
      end
      default: mc_state_d = MC_IDLE;
    endcase
    if (consume) begin
      mc_state_d = MC_IDLE;
      if (grant) begin
        mc_state_d = MC_REQ;
        mc_addr_d  = dmem_addr & ~XLEN'(3);
        mc_strb_d  = dmem_strb;
        mc_wen_d   = dmem_wen;
        mc_wdata_d = dmem_wen ? dmem_wdata : '0;
        mc_rdata_d = '0;
      end
    end
  end

  // A load response arriving with its retirement is forwarded directly.
  assign ld_rdata = (mc_state_q == MC_REQ) ? dmem_rdata : mc_rdata_q;

  assign mem_ok = trs_mem && !trs_trap &&
                  ((mc_state_q == MC_DONE) ||
                   ((mc_state_q == MC_REQ) &&
                    (mc_wen_q || dmem_recv)));

  // Build the record for the retiring instruction.
  always_comb begin
    rec_d           = '0;
    rec_d.trap      = trs_trap;
    rec_d.halt      = trs_halt;
    rec_d.intr      = intr_q;
    rec_d.order     = order_q;
    rec_d.insn      = trs_insn;
    rec_d.rs1_addr  = trs_rs1_addr;
    rec_d.rs2_addr  = trs_rs2_addr;
    rec_d.rs3_addr  = trs_rs3_addr;
    if (trs_rs1_addr != 5'd0) rec_d.rs1_rdata = trs_rs1_rdata;
    if (trs_rs2_addr != 5'd0) rec_d.rs2_rdata = trs_rs2_rdata;
    if (trs_rs3_addr != 5'd0) rec_d.rs3_rdata = trs_rs3_rdata;
    rec_d.pc_rdata  = trs_pc;
    rec_d.pc_wdata  = trs_pc_next;
    if (!trs_trap) begin
      rec_d.rd_addr = trs_rd_addr;
      if (trs_rd_addr != 5'd0) rec_d.rd_wdata = trs_rd_wdata;
`ifdef FRV_RVFI_WIDE_EN
      rec_d.rd_wide = trs_rd_wide;
      if (trs_rd_addr != 5'd0) rec_d.rd_wdatahi = trs_rd_wdatahi;
`endif
    end
    if (mem_ok) begin
      rec_d.mem_addr = mc_addr_q;
      if (mc_wen_q) begin
        rec_d.mem_wmask = mc_strb_q;
        rec_d.mem_wdata = mc_wdata_q;
      end else begin
        rec_d.mem_rmask = mc_strb_q;
        rec_d.mem_rdata = ld_rdata;
      end
    end
  end

`ifndef FRV_RVFI_WIDE_EN
  logic unused_wide;
  assign unused_wide = ^{trs_rd_wide, trs_rd_wdatahi};
`endif

  // Capture register and trace state; reset overrides any retirement.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      mc_state_q <= MC_IDLE;
      mc_addr_q  <= '0;
      mc_strb_q  <= '0;
      mc_wen_q   <= 1'b0;
      mc_wdata_q <= '0;
      mc_rdata_q <= '0;
      rec_q      <= '0;
      valid_q    <= 1'b0;
      order_q    <= '0;
      intr_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mc_state_q <= mc_state_d;
      mc_addr_q  <= mc_addr_d;
      mc_strb_q  <= mc_strb_d;
      mc_wen_q   <= mc_wen_d;
      mc_wdata_q <= mc_wdata_d;
      mc_rdata_q <= mc_rdata_d;
      valid_q    <= accept;
      if (accept) begin
        rec_q    <= rec_d;
        order_q  <= order_q + 64'd1;
        intr_q   <= trs_trap;
        halted_q <= trs_halt;
      end
    end
  end

  assign rvfi_valid      = valid_q;
  assign rvfi_trap       = rec_q.trap;
  assign rvfi_halt       = rec_q.halt;
  assign rvfi_intr       = rec_q.intr;
  assign rvfi_order      = rec_q.order;
  assign rvfi_insn       = rec_q.insn;
  assign rvfi_rs1_addr   = rec_q.rs1_addr;
  assign rvfi_rs2_addr   = rec_q.rs2_addr;
  assign rvfi_rs3_addr   = rec_q.rs3_addr;
  assign rvfi_rs1_rdata  = rec_q.rs1_rdata;
  assign rvfi_rs2_rdata  = rec_q.rs2_rdata;
  assign rvfi_rs3_rdata  = rec_q.rs3_rdata;
  assign rvfi_rd_addr    = rec_q.rd_addr;
  assign rvfi_rd_wdata   = rec_q.rd_wdata;
  assign rvfi_rd_wdatahi = rec_q.rd_wdatahi;
  assign rvfi_rd_wide    = rec_q.rd_wide;
  assign rvfi_pc_rdata   = rec_q.pc_rdata;
  assign rvfi_pc_wdata   = rec_q.pc_wdata;
  assign rvfi_mem_addr   = rec_q.mem_addr;
  assign rvfi_mem_rdata  = rec_q.mem_rdata;
  assign rvfi_mem_wdata  = rec_q.mem_wdata;
  assign rvfi_mem_rmask  = rec_q.mem_rmask;
  assign rvfi_mem_wmask  = rec_q.mem_wmask;

endmodule

// File: tb/tb_frv_rvfi_tracer.sv
// Scoreboard bench for frv_rvfi_tracer.
// Wide expectations follow FRV_RVFI_WIDE_EN.
module tb_frv_rvfi_tracer;

`ifdef FRV_RVFI_WIDE_EN
  localparam logic WIDE = 1'b1;
`else
  localparam logic WIDE = 1'b0;
`endif
  localparam logic [31:0] WHI = WIDE ? 32'h12345678 : 32'h0;

  typedef struct packed {
    logic        trap;
    logic        halt;
    logic        intr;
    logic [63:0] order;
    logic [31:0] insn;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [4:0]  rs3a;
    logic [31:0] rs3d;
    logic [4:0]  rda;
    logic [31:0] rdd;
    logic [31:0] rdhi;
    logic        wide;
    logic [31:0] pcr;
    logic [31:0] pcw;
    logic [31:0] ma;
    logic [31:0] mr;
    logic [31:0] mw;
    logic [3:0]  rm;
    logic [3:0]  wm;
  } rec_t;

  logic g_clk = 1'b0;
  logic g_reset;
  logic trs_valid, trs_trap, trs_halt, trs_rd_wide, trs_mem;
  logic [31:0] trs_pc, trs_pc_next, trs_insn;
  logic [4:0]  trs_rs1_addr, trs_rs2_addr, trs_rs3_addr, trs_rd_addr;
  logic [31:0] trs_rs1_rdata, trs_rs2_rdata, trs_rs3_rdata;
  logic [31:0] trs_rd_wdata, trs_rd_wdatahi;
  logic dmem_req, dmem_gnt, dmem_wen, dmem_recv;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rd_wide;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
  logic [31:0] rvfi_rd_wdata, rvfi_rd_wdatahi;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

  rec_t act;
  rec_t q[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_order = 64'd0;

  frv_rvfi_tracer #(.XLEN(32), .ILEN(32)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .trs_valid(trs_valid), .trs_pc(trs_pc), .trs_pc_next(trs_pc_next),
    .trs_insn(trs_insn), .trs_trap(trs_trap), .trs_halt(trs_halt),
    .trs_rs1_addr(trs_rs1_addr), .trs_rs2_addr(trs_rs2_addr),
    .trs_rs3_addr(trs_rs3_addr), .trs_rs1_rdata(trs_rs1_rdata),
    .trs_rs2_rdata(trs_rs2_rdata), .trs_rs3_rdata(trs_rs3_rdata),
    .trs_rd_addr(trs_rd_addr), .trs_rd_wdata(trs_rd_wdata),
    .trs_rd_wdatahi(trs_rd_wdatahi), .trs_rd_wide(trs_rd_wide),
    .trs_mem(trs_mem), .dmem_req(dmem_req), .dmem_gnt(dmem_gnt),
    .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_recv(dmem_recv),
    .dmem_rdata(dmem_rdata),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_wdatahi(rvfi_rd_wdatahi), .rvfi_rd_wide(rvfi_rd_wide),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask)
  );

  always #5 g_clk = ~g_clk;

  assign act = {rvfi_trap, rvfi_halt, rvfi_intr, rvfi_order,
                rvfi_insn, rvfi_rs1_addr, rvfi_rs1_rdata,
                rvfi_rs2_addr, rvfi_rs2_rdata, rvfi_rs3_addr,
                rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata,
                rvfi_rd_wdatahi, rvfi_rd_wide, rvfi_pc_rdata,
                rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata,
                rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask};

  // Monitor: every presented record must match the queue head.
  always @(negedge g_clk) begin
    rec_t e;
    if (rvfi_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got=%h required=none", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL record_order%0d got=%h required=%h",
                   e.order, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clr();
    trs_valid = 0; trs_trap = 0; trs_halt = 0; trs_mem = 0;
    trs_rd_wide = 0; trs_rd_wdatahi = 0;
    dmem_req = 0; dmem_gnt = 0; dmem_recv = 0;
  endtask

  task automatic grant(input logic [31:0] a, input logic [3:0] s,
                       input logic w, input logic [31:0] d);
    dmem_req = 1; dmem_gnt = 1;
    dmem_addr = a; dmem_strb = s; dmem_wen = w; dmem_wdata = d;
  endtask

  task automatic recv(input logic [31:0] d);
    dmem_recv = 1; dmem_rdata = d;
  endtask

  task automatic pulse();
    trs_valid = 1; trs_pc = 32'hBAD0; trs_pc_next = 32'hBAD4;
    trs_insn = 32'h13; trs_trap = 0; trs_halt = 0; trs_mem = 0;
  endtask

  task automatic chk_reset();
    @(negedge g_clk);
    checks++;
    if (rvfi_valid !== 1'b0 || act !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b got=%h required=0",
               rvfi_valid, act);
    end
  endtask

  task automatic ret(
    input logic [31:0] pc, insn,
    input logic [4:0]  r1a, input logic [31:0] r1d,
    input logic [4:0]  r2a, input logic [31:0] r2d,
    input logic [4:0]  rda, input logic [31:0] wd, hi,
    input logic wide, trap, halt, mem,
    input logic [31:0] e_r2d, input logic [4:0] e_rda,
    input logic [31:0] e_wd, e_hi,
    input logic e_wide, e_intr,
    input logic [31:0] e_ma, e_mr, e_mw,
    input logic [3:0]  e_rm, e_wm);
    rec_t e;
    trs_valid = 1; trs_pc = pc; trs_pc_next = pc + 32'd4;
    trs_insn = insn; trs_trap = trap; trs_halt = halt;
    trs_rs1_addr = r1a; trs_rs1_rdata = r1d;
    trs_rs2_addr = r2a; trs_rs2_rdata = r2d;
    trs_rs3_addr = 5'd3; trs_rs3_rdata = 32'h333;
    trs_rd_addr = rda; trs_rd_wdata = wd;
    trs_rd_wdatahi = hi; trs_rd_wide = wide; trs_mem = mem;
    e = '0;
    e.trap = trap; e.halt = halt; e.intr = e_intr;
    e.order = exp_order; e.insn = insn;
    e.rs1a = r1a; e.rs1d = r1d; e.rs2a = r2a; e.rs2d = e_r2d;
    e.rs3a = 5'd3; e.rs3d = 32'h333;
    e.rda = e_rda; e.rdd = e_wd; e.rdhi = e_hi; e.wide = e_wide;
    e.pcr = pc; e.pcw = pc + 32'd4;
    e.ma = e_ma; e.mr = e_mr; e.mw = e_mw; e.rm = e_rm; e.wm = e_wm;
    q.push_back(e);
    exp_order = exp_order + 64'd1;
  endtask

  initial begin
    g_reset = 1;
    dmem_addr = 0; dmem_strb = 0; dmem_wen = 0;
    dmem_wdata = 0; dmem_rdata = 0;
    trs_pc = 0; trs_pc_next = 0; trs_insn = 0;
    trs_rs1_addr = 0; trs_rs2_addr = 0; trs_rs3_addr = 0;
    trs_rs1_rdata = 0; trs_rs2_rdata = 0; trs_rs3_rdata = 0;
    trs_rd_addr = 0; trs_rd_wdata = 0;
    clr();
    repeat (3) tick();
    g_reset = 0;
    chk_reset();

    // three back-to-back ALU ops; rd=0 and rs2=0 zeroing; wide write
    tick();
    ret(32'h100, 32'h00500093, 5'd1, 32'h11, 5'd2, 32'h22,
        5'd1, 32'h5, 32'h0, 0, 0, 0, 0,
        32'h22, 5'd1, 32'h5, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ret(32'h104, 32'h07700013, 5'd1, 32'h11, 5'd0, 32'h99,
        5'd0, 32'h77, 32'hABCD, 0, 0, 0, 0,
        32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ret(32'h108, 32'h003101b3, 5'd2, 32'h22, 5'd4, 32'h44,
        5'd3, 32'h33, 32'h12345678, 1, 0, 0, 0,
        32'h44, 5'd3, 32'h33, WHI, WIDE, 0, 0, 0, 0, 0, 0);
    tick(); clr();

    // load: misaligned grant address, response, then retire
    grant(32'h1003, 4'h8, 0, 32'h0);
    tick(); clr(); tick();
    recv(32'hAABBCCDD);
    tick(); clr();
    ret(32'h200, 32'h0030a203, 5'd1, 32'h1000, 5'd0, 32'h0,
        5'd4, 32'hAA, 32'h0, 0, 0, 0, 1,
        32'h0, 5'd4, 32'hAA, 32'h0, 0, 0,
        32'h1000, 32'hAABBCCDD, 32'h0, 4'h8, 4'h0);
    tick(); clr();

    // store retires while the next load is granted
    grant(32'h2004, 4'hF, 1, 32'hCAFEF00D);
    tick(); clr();
    recv(32'h55);
    tick(); clr();
    ret(32'h204, 32'h00112223, 5'd1, 32'h2004, 5'd2, 32'hCAFEF00D,
        5'd0, 32'h0, 32'h0, 0, 0, 0, 1,
        32'hCAFEF00D, 5'd0, 32'h0, 32'h0, 0, 0,
        32'h2004, 32'h0, 32'hCAFEF00D, 4'h0, 4'hF);
    grant(32'h3002, 4'h4, 0, 32'h123);
    tick(); clr();
    // response coincident with the consuming retirement
    ret(32'h208, 32'h0020c303, 5'd1, 32'h3002, 5'd0, 32'h0,
        5'd6, 32'h04, 32'h0, 0, 0, 0, 1,
        32'h0, 5'd6, 32'h04, 32'h0, 0, 0,
        32'h3000, 32'h01020304, 32'h0, 4'h4, 4'h0);
    recv(32'h01020304);
    tick(); clr();

    // load retiring while still waiting for its response
    grant(32'h5000, 4'hF, 0, 32'h0);
    tick(); clr();
    ret(32'h20C, 32'h0000a383, 5'd1, 32'h5000, 5'd0, 32'h0,
        5'd7, 32'h7, 32'h0, 0, 0, 0, 1,
        32'h0, 5'd7, 32'h7, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();

    // trapping load, then intr on the next record only
    grant(32'h4000, 4'h1, 0, 32'h0);
    tick(); clr();
    recv(32'hFF);
    tick(); clr();
    ret(32'h210, 32'h0000c283, 5'd1, 32'h4000, 5'd0, 32'h0,
        5'd5, 32'h55, 32'h9, 1, 1, 0, 1,
        32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ret(32'h300, 32'h00100093, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd1, 32'h1, 32'h0, 0, 0, 0, 0,
        32'h2, 5'd1, 32'h1, 32'h0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    ret(32'h304, 32'h00200093, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd1, 32'h2, 32'h0, 0, 0, 0, 0,
        32'h2, 5'd1, 32'h2, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // back-to-back traps
    ret(32'h308, 32'h00000073, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd8, 32'h8, 32'h0, 0, 1, 0, 0,
        32'h2, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ret(32'h30C, 32'h00000073, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd9, 32'h9, 32'h0, 0, 1, 0, 0,
        32'h2, 5'd0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    ret(32'h310, 32'h00300093, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd1, 32'h3, 32'h0, 0, 0, 0, 0,
        32'h2, 5'd1, 32'h3, 32'h0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    ret(32'h314, 32'h00400093, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd1, 32'h4, 32'h0, 0, 0, 0, 0,
        32'h2, 5'd1, 32'h4, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // halt, then further retirements are ignored
    ret(32'h318, 32'h00100073, 5'd1, 32'h1, 5'd2, 32'h2,
        5'd0, 32'h0, 32'h0, 0, 0, 1, 0,
        32'h2, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      pulse(); tick(); clr(); tick();
    end

    // reset clears halt and order
    g_reset = 1;
    repeat (2) tick();
    g_reset = 0;
    exp_order = 64'd0;
    chk_reset();
    tick();

    // reset beside a retirement and mid-transaction
    grant(32'h6000, 4'hF, 0, 32'h0);
    tick(); clr();
    g_reset = 1; pulse();
    tick(); clr();
    g_reset = 0;
    chk_reset();
    tick();
    recv(32'h77);
    tick(); clr();
    ret(32'h400, 32'h0000a403, 5'd1, 32'h6000, 5'd0, 32'h0,
        5'd8, 32'h88, 32'h0, 0, 0, 0, 1,
        32'h0, 5'd8, 32'h88, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();

    repeat (4) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_records got=%0d left required=0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
